// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the single-port memory
//                arbiter (FSM state encoding, ResultSrc load encoding).
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    FETCH  = 2'd2,
    DONE_D = 2'd3
  } arb_state_t;

  // ResultSrcM encoding that marks a load in the memory stage
  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

  // Width of the memory-ack timeout counter
  localparam int TMO_CW = 8;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/register.sv
`default_nettype none
// ============================================================================
//  Module      : register
//  Description : Enabled D-register with asynchronous active-high reset to 0.
//  Revision    : 1.0 - initial release
//  Ports       : clk, rst  - clock / async reset
//                en        - load enable
//                d / q     - data in / registered data out (W bits)
// ============================================================================
module register #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule : register
`default_nettype wire

// File: rtl/timeout_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : timeout_ctr
//  Description : Cycle counter for an outstanding memory access. Counts while
//                enabled; 'expired' is high during the cycle that is the
//                'limit'-th enabled cycle since the last clear.
//  Revision    : 1.0 - initial release
//  Ports       : clk, rst  - clock / async reset
//                clr       - synchronous clear (counter idle)
//                en        - count this cycle
//                limit     - cycle budget
//                expired   - budget used up in the current cycle
// ============================================================================
import mem_arb_pkg::*;

module timeout_ctr (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [TMO_CW-1:0] limit,
  output logic              expired
);

  logic [TMO_CW-1:0] cnt_q;
  logic [TMO_CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && (cnt_q != {TMO_CW{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // cnt_q is 0 in the first counted cycle, so the limit-th cycle has
  // cnt_q == limit-1. Compared one bit wider so limit==0 cannot wrap.
  assign expired = en && !clr &&
                   (({1'b0, cnt_q} + {{TMO_CW{1'b0}}, 1'b1}) >= {1'b0, limit});

endmodule : timeout_ctr
`default_nettype wire

// File: rtl/mem_port_arb.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arb
//  Description : Shares one unified memory port between fetch (F) and memory
//                stage (M). Data accesses win arbitration; accesses are
//                serialised and the pipeline stall controls are generated.
//  Revision    : 1.0 - initial release
//  Option      : MEM_ARB_PERF_EN adds stall/timeout performance counters
//  Ports       : clk, rst             - clock / async active-high reset
//                if_req, if_addr      - fetch request / PC
//                if_rdata, if_valid   - fetched instruction / 1-cycle valid
//                ResultSrcM,MemWriteM - M-stage load / store indication
//                dm_addr, dm_wdata    - data address / store data
//                dm_rdata             - load result
//                stall_pipe           - freeze all pipeline registers
//                stall_fetch          - freeze PC and F/D
//                mem_req/we/addr/wdata- memory request side
//                mem_rdata, mem_ack   - memory response side
//                mem_err              - sticky timeout flag
//                perf_*               - performance counters (option only)
// ============================================================================
import mem_arb_pkg::*;

module mem_port_arb #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TMO = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic [1:0]    ResultSrcM,
  input  logic          MemWriteM,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          stall_pipe,
  output logic          stall_fetch,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          mem_err
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]   perf_stall_pipe,
  output logic [31:0]   perf_stall_fetch,
  output logic [31:0]   perf_timeout
`endif
);

  localparam logic [TMO_CW-1:0] c_tmo_limit = TMO_CW'(TMO);

  arb_state_t    state_q, state_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d;
  logic          if_valid_q, if_valid_d;
  logic          mem_err_q, mem_err_d;

  logic          dm_req;
  logic          running;
  logic          tmo_expired;
  logic          timeout_evt;
  logic          if_lat_en;
  logic          dm_lat_en;
  logic [DW-1:0] dm_lat_d;

  assign dm_req  = MemWriteM | (ResultSrcM == RESULTSRC_LOAD);
  assign running = (state_q == DATA) || (state_q == FETCH);

  // Counter is held clear outside DATA/FETCH, so every entry starts at 0.
  timeout_ctr u_timeout_ctr (
    .clk     (clk),
    .rst     (rst),
    .clr     (!running),
    .en      (running),
    .limit   (c_tmo_limit),
    .expired (tmo_expired)
  );

  // An ack in the last budgeted cycle still counts as success.
  assign timeout_evt = running && !mem_ack && tmo_expired;

  // --------------------------------------------------------------------------
  // FSM next state and grant-time capture of the request fields
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    case (state_q)
      IDLE: begin
        if (dm_req) begin
          state_d     = DATA;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_we_d    = MemWriteM;
        end else if (if_req) begin
          state_d     = FETCH;
          mem_addr_d  = if_addr;
          mem_we_d    = 1'b0;
        end
      end
      // A data timeout still passes through DONE_D so M can advance.
      DATA:    if (mem_ack || timeout_evt) state_d = DONE_D;
      FETCH:   if (mem_ack || timeout_evt) state_d = IDLE;
      DONE_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign if_valid_d = (state_q == FETCH) && mem_ack;
  assign mem_err_d  = mem_err_q | timeout_evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      if_valid_q  <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      if_valid_q  <= if_valid_d;
      mem_err_q   <= mem_err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Result latches
  // --------------------------------------------------------------------------
  assign if_lat_en = if_valid_d;
  // Loads capture the returned word; a timed-out access returns 0.
  assign dm_lat_en = (state_q == DATA) && ((mem_ack && !mem_we_q) || timeout_evt);
  assign dm_lat_d  = mem_ack ? mem_rdata : '0;

  register #(.W(DW)) u_if_rdata (
    .clk (clk),
    .rst (rst),
    .en  (if_lat_en),
    .d   (mem_rdata),
    .q   (if_rdata)
  );

  register #(.W(DW)) u_dm_rdata (
    .clk (clk),
    .rst (rst),
    .en  (dm_lat_en),
    .d   (dm_lat_d),
    .q   (dm_rdata)
  );

  // --------------------------------------------------------------------------
  // Outputs. mem_req is decoded from the state flop so an asynchronous reset
  // drops it at once. Stalls are forced low while reset is asserted so that
  // every output reads 0 during reset.
  // --------------------------------------------------------------------------
  assign mem_req     = running;
  assign mem_we      = running && mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign if_valid    = if_valid_q;
  assign mem_err     = mem_err_q;
  assign stall_pipe  = !rst && dm_req && (state_q != DONE_D);
  assign stall_fetch = !rst && (!if_valid_q || stall_pipe);

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_sp_q, perf_sp_d;
  logic [31:0] perf_sf_q, perf_sf_d;
  logic [31:0] perf_to_q, perf_to_d;

  always_comb begin
    perf_sp_d = perf_sp_q + {31'd0, stall_pipe};
    perf_sf_d = perf_sf_q + {31'd0, stall_fetch};
    perf_to_d = perf_to_q + {31'd0, timeout_evt};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_sp_q <= '0;
      perf_sf_q <= '0;
      perf_to_q <= '0;
    end else begin
      perf_sp_q <= perf_sp_d;
      perf_sf_q <= perf_sf_d;
      perf_to_q <= perf_to_d;
    end
  end

  assign perf_stall_pipe  = perf_sp_q;
  assign perf_stall_fetch = perf_sf_q;
  assign perf_timeout     = perf_to_q;
`endif

endmodule : mem_port_arb
`default_nettype wire
